// File: rtl/univ_shift_reg_pkg.sv
// +----------------------------------------------------------------------+
// | univ_shift_reg_pkg : mode encoding shared by the universal register  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

package univ_shift_reg_pkg;

  localparam int USR_MODE_W = 3;

  typedef enum logic [USR_MODE_W-1:0] {
    USR_HOLD  = 3'd0,
    USR_LOAD  = 3'd1,
    USR_SHL   = 3'd2,
    USR_SHR   = 3'd3,
    USR_ROL   = 3'd4,
    USR_ROR   = 3'd5,
    USR_CNTUP = 3'd6,
    USR_CNTDN = 3'd7
  } usr_mode_e;

endpackage

`default_nettype wire

// File: rtl/usr_next_calc.sv
// +----------------------------------------------------------------------+
// | usr_next_calc : next-state and wrap-condition logic of univ_shift_reg|
// | Counting modes exist only when UNIV_SHIFT_REG_COUNT_EN is defined.   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module usr_next_calc
  import univ_shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_q,
  input  usr_mode_e        i_mode,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_sin_lsb,
  input  logic             i_sin_msb,
  output logic [WIDTH-1:0] o_q_next,
  output logic             o_wrap
);

`ifdef UNIV_SHIFT_REG_COUNT_EN
  localparam logic [WIDTH-1:0] c_one = WIDTH'(1);
`endif

  always_comb begin
    o_q_next = i_q;
    o_wrap   = 1'b0;
    case (i_mode)
      USR_LOAD: o_q_next = i_d;
      USR_SHL:  o_q_next = {i_q[WIDTH-2:0], i_sin_lsb};
      USR_SHR:  o_q_next = {i_sin_msb, i_q[WIDTH-1:1]};
      USR_ROL:  o_q_next = {i_q[WIDTH-2:0], i_q[WIDTH-1]};
      USR_ROR:  o_q_next = {i_q[0], i_q[WIDTH-1:1]};
`ifdef UNIV_SHIFT_REG_COUNT_EN
      USR_CNTUP: begin
        o_q_next = i_q + c_one;
        o_wrap   = &i_q;
      end
      USR_CNTDN: begin
        o_q_next = i_q - c_one;
        o_wrap   = ~|i_q;
      end
`endif
      // HOLD, and the count modes when counting is compiled out
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/univ_shift_reg.sv
// +----------------------------------------------------------------------+
// | univ_shift_reg : WIDTH-bit universal register, async clear/preset,   |
// | mode-selected update. Macro UNIV_SHIFT_REG_COUNT_EN enables counting.|
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module univ_shift_reg
  import univ_shift_reg_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] PRESET_VAL = {WIDTH{1'b1}}
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  apreset,
  input  logic                  en,
  input  logic [USR_MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]      d,
  input  logic                  sin_lsb,
  input  logic                  sin_msb,
  output logic [WIDTH-1:0]      q,
  output logic [WIDTH-1:0]      qn,
  output logic                  sout_msb,
  output logic                  sout_lsb,
  output logic                  wrap
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_next;
  logic             w_wrap_cond;

  usr_next_calc #(
    .WIDTH (WIDTH)
  ) u_next (
    .i_q       (r_q),
    .i_mode    (usr_mode_e'(mode)),
    .i_d       (d),
    .i_sin_lsb (sin_lsb),
    .i_sin_msb (sin_msb),
    .o_q_next  (w_q_next),
    .o_wrap    (w_wrap_cond)
  );

  // arst outranks apreset; both override the clock
  always_ff @(posedge clk or posedge arst or posedge apreset) begin
    if (arst)         r_q <= '0;
    else if (apreset) r_q <= PRESET_VAL;
    else if (en)      r_q <= w_q_next;
  end

`ifdef UNIV_SHIFT_REG_COUNT_EN
  logic r_wrap;

  always_ff @(posedge clk or posedge arst or posedge apreset) begin
    if (arst || apreset) r_wrap <= 1'b0;
    else                 r_wrap <= en & w_wrap_cond;
  end

  assign wrap = r_wrap;
`else
  // the wrap condition is a constant 0 when counting is compiled out
  assign wrap = w_wrap_cond;
`endif

  assign q        = r_q;
  assign qn       = ~r_q;
  assign sout_msb = r_q[WIDTH-1];
  assign sout_lsb = r_q[0];

endmodule

`default_nettype wire

// File: tb/tb_univ_shift_reg.sv
// +----------------------------------------------------------------------+
// | tb_univ_shift_reg : directed self-checking bench for univ_shift_reg  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_univ_shift_reg;

  logic       clk = 1'b0;
  logic       arst = 1'b0;
  logic       apreset = 1'b0;
  logic       en = 1'b0;
  logic [2:0] mode = 3'd0;
  logic [7:0] d = 8'h00;
  logic       sin_lsb = 1'b0;
  logic       sin_msb = 1'b0;
  logic [7:0] q;
  logic [7:0] qn;
  logic       sout_msb;
  logic       sout_lsb;
  logic       wrap;

  int n_cmp = 0;
  int n_err = 0;

  univ_shift_reg #(
    .WIDTH      (8),
    .PRESET_VAL (8'hA5)
  ) dut (
    .clk      (clk),
    .arst     (arst),
    .apreset  (apreset),
    .en       (en),
    .mode     (mode),
    .d        (d),
    .sin_lsb  (sin_lsb),
    .sin_msb  (sin_msb),
    .q        (q),
    .qn       (qn),
    .sout_msb (sout_msb),
    .sout_lsb (sout_lsb),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic e, input logic [2:0] m, input logic [7:0] dv);
    en   = e;
    mode = m;
    d    = dv;
    tick();
  endtask

  initial begin
    // reset state
    #1 arst = 1'b1;
    #1;
    chk("rst_q", q, 8'h00);
    chk("rst_qn", qn, 8'hFF);
    chk("rst_sout_msb", {7'd0, sout_msb}, 8'h00);
    chk("rst_sout_lsb", {7'd0, sout_lsb}, 8'h00);
    chk("rst_wrap", {7'd0, wrap}, 8'h00);
    @(negedge clk);
    arst = 1'b0;

    // load, then disabled shifting holds
    drive(1'b1, 3'd1, 8'h3C);
    chk("load_3c", q, 8'h3C);
    drive(1'b0, 3'd2, 8'h00);
    drive(1'b0, 3'd2, 8'h00);
    drive(1'b0, 3'd2, 8'h00);
    chk("en0_hold", q, 8'h3C);
    chk("en0_wrap", {7'd0, wrap}, 8'h00);
    drive(1'b1, 3'd0, 8'hFF);
    chk("mode_hold", q, 8'h3C);

    // shifts
    drive(1'b1, 3'd1, 8'h81);
    sin_lsb = 1'b1;
    drive(1'b1, 3'd2, 8'h00);
    chk("shl_81", q, 8'h03);
    chk("shl_sout_msb", {7'd0, sout_msb}, 8'h00);
    chk("shl_sout_lsb", {7'd0, sout_lsb}, 8'h01);
    sin_lsb = 1'b0;
    drive(1'b1, 3'd1, 8'h81);
    sin_msb = 1'b0;
    drive(1'b1, 3'd3, 8'h00);
    chk("shr_81", q, 8'h40);
    sin_msb = 1'b1;
    drive(1'b1, 3'd3, 8'h00);
    chk("shr_in1", q, 8'hA0);
    chk("shr_qn", qn, 8'h5F);
    sin_msb = 1'b0;

    // rotates
    drive(1'b1, 3'd1, 8'h81);
    drive(1'b1, 3'd4, 8'h00);
    chk("rol_81", q, 8'h03);
    drive(1'b1, 3'd1, 8'h81);
    drive(1'b1, 3'd5, 8'h00);
    chk("ror_81", q, 8'hC0);
    drive(1'b1, 3'd1, 8'h5A);
    drive(1'b1, 3'd4, 8'h00);
    chk("rol_5a_1", q, 8'hB4);
    for (int i = 0; i < 7; i++) drive(1'b1, 3'd4, 8'h00);
    chk("rol_5a_8", q, 8'h5A);

`ifdef UNIV_SHIFT_REG_COUNT_EN
    drive(1'b1, 3'd1, 8'hFE);
    drive(1'b1, 3'd6, 8'h00);
    chk("up_ff", q, 8'hFF);
    chk("up_ff_wrap", {7'd0, wrap}, 8'h00);
    drive(1'b1, 3'd6, 8'h00);
    chk("up_00", q, 8'h00);
    chk("up_00_wrap", {7'd0, wrap}, 8'h01);
    drive(1'b1, 3'd0, 8'h00);
    chk("wrap_one_cycle", {7'd0, wrap}, 8'h00);
    drive(1'b1, 3'd7, 8'h00);
    chk("dn_ff", q, 8'hFF);
    chk("dn_ff_wrap", {7'd0, wrap}, 8'h01);
    drive(1'b1, 3'd7, 8'h00);
    chk("dn_fe", q, 8'hFE);
    chk("dn_fe_wrap", {7'd0, wrap}, 8'h00);
    drive(1'b1, 3'd1, 8'hFF);
    drive(1'b0, 3'd6, 8'h00);
    chk("en0_cnt_q", q, 8'hFF);
    chk("en0_cnt_wrap", {7'd0, wrap}, 8'h00);
    drive(1'b1, 3'd6, 8'h00);
    chk("up_wrap_again", {7'd0, wrap}, 8'h01);
    apreset = 1'b1;
    #1;
    chk("preset_q", q, 8'hA5);
    chk("preset_wrap", {7'd0, wrap}, 8'h00);
    @(negedge clk);
    apreset = 1'b0;
`else
    drive(1'b1, 3'd1, 8'h10);
    for (int i = 0; i < 4; i++) drive(1'b1, 3'd6, 8'h00);
    chk("nocnt_up_q", q, 8'h10);
    chk("nocnt_up_wrap", {7'd0, wrap}, 8'h00);
    drive(1'b1, 3'd7, 8'h00);
    chk("nocnt_dn_q", q, 8'h10);
    chk("nocnt_dn_wrap", {7'd0, wrap}, 8'h00);
    apreset = 1'b1;
    #1;
    chk("preset_q", q, 8'hA5);
    @(negedge clk);
    apreset = 1'b0;
`endif

    // mid-operation clear, both resets, release arst under preset
    drive(1'b1, 3'd1, 8'h81);
    en   = 1'b1;
    mode = 3'd4;
    #2 arst = 1'b1;
    #1;
    chk("arst_mid_q", q, 8'h00);
    chk("arst_mid_qn", qn, 8'hFF);
    chk("arst_mid_wrap", {7'd0, wrap}, 8'h00);
    apreset = 1'b1;
    #1;
    chk("both_q", q, 8'h00);
    arst = 1'b0;
    tick();
    chk("arst_rel_q", q, 8'hA5);
    chk("arst_rel_qn", qn, 8'h5A);
    tick();
    chk("preset_hold_q", q, 8'hA5);
    apreset = 1'b0;
    drive(1'b1, 3'd1, 8'h77);
    chk("first_edge_load", q, 8'h77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
